// File: rtl/nn_weight_ld.sv
// nn_weight_ld: fetches weight lines from memory and streams one weight per
// cycle into neuron layers A, B, C; each neuron starts on a fresh line.
// Ports: clk, rst (sync, active-high), go/layer_en/abort control,
//   req_mem/mem_ready/mem_data memory side, write_x/x_sel/x_weight_sel/
//   x_weight_bus per layer, weight_valid, busy, cksum.
// Optional: define NN_WEIGHT_LD_CKSUM_EN to build the running weight checksum.
module nn_weight_ld #(
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 32,
    parameter int A_NEURONS  = 15,
    parameter int A_WEIGHTS  = 401,
    parameter int B_NEURONS  = 15,
    parameter int B_WEIGHTS  = 16,
    parameter int C_NEURONS  = 36,
    parameter int C_WEIGHTS  = 16,
    localparam int AN_W = (A_NEURONS > 1) ? $clog2(A_NEURONS) : 1,
    localparam int BN_W = (B_NEURONS > 1) ? $clog2(B_NEURONS) : 1,
    localparam int CN_W = (C_NEURONS > 1) ? $clog2(C_NEURONS) : 1,
    localparam int AW_W = (A_WEIGHTS > 1) ? $clog2(A_WEIGHTS) : 1,
    localparam int BW_W = (B_WEIGHTS > 1) ? $clog2(B_WEIGHTS) : 1,
    localparam int CW_W = (C_WEIGHTS > 1) ? $clog2(C_WEIGHTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic [2:0]                   layer_en,
    input  logic                         abort,
    input  logic                         mem_ready,
    input  logic [LINE_WORDS*DATA_W-1:0] mem_data,
    output logic                         req_mem,
    output logic                         write_a,
    output logic                         write_b,
    output logic                         write_c,
    output logic [AN_W-1:0]              a_sel,
    output logic [BN_W-1:0]              b_sel,
    output logic [CN_W-1:0]              c_sel,
    output logic [AW_W-1:0]              a_weight_sel,
    output logic [BW_W-1:0]              b_weight_sel,
    output logic [CW_W-1:0]              c_weight_sel,
    output logic [DATA_W-1:0]            a_weight_bus,
    output logic [DATA_W-1:0]            b_weight_bus,
    output logic [DATA_W-1:0]            c_weight_bus,
    output logic                         weight_valid,
    output logic                         busy,
    output logic [31:0]                  cksum
);

    localparam int NC_W = (AN_W > BN_W) ? ((AN_W > CN_W) ? AN_W : CN_W)
                                        : ((BN_W > CN_W) ? BN_W : CN_W);
    localparam int WC_W = (AW_W > BW_W) ? ((AW_W > CW_W) ? AW_W : CW_W)
                                        : ((BW_W > CW_W) ? BW_W : CW_W);
    localparam int LW_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE} state_t;
    typedef enum logic [1:0] {L_A, L_B, L_C, L_NONE} layer_t;

    state_t state, state_n;
    layer_t layer, layer_n, layer_nx;
    logic [2:0] en_q, en_n;
    logic [NC_W-1:0] nrn, nrn_n;
    logic [WC_W-1:0] wcnt, wcnt_n;
    logic [LW_W-1:0] word, word_n;
    logic [LINE_WORDS-1:0][DATA_W-1:0] line_q, line_n;
    logic last_w, last_n, last_word;
    logic emit_n;
    logic [DATA_W-1:0] word_val;

    // Counters index the weight that is on the write bus while in EMIT;
    // outputs are registered from the next-state values.
    always_comb begin
        last_w = 1'b1;
        last_n = 1'b1;
        unique case (layer)
            L_A: begin
                last_w = (wcnt == WC_W'(A_WEIGHTS - 1));
                last_n = (nrn == NC_W'(A_NEURONS - 1));
            end
            L_B: begin
                last_w = (wcnt == WC_W'(B_WEIGHTS - 1));
                last_n = (nrn == NC_W'(B_NEURONS - 1));
            end
            L_C: begin
                last_w = (wcnt == WC_W'(C_WEIGHTS - 1));
                last_n = (nrn == NC_W'(C_NEURONS - 1));
            end
            default: ;
        endcase
        last_word = (word == LW_W'(LINE_WORDS - 1));

        layer_nx = L_NONE;
        if (layer == L_A && en_q[1])
            layer_nx = L_B;
        else if (layer != L_C && en_q[2])
            layer_nx = L_C;

        state_n = state;
        layer_n = layer;
        en_n    = en_q;
        nrn_n   = nrn;
        wcnt_n  = wcnt;
        word_n  = word;
        line_n  = line_q;

        if (abort) begin
            state_n = S_IDLE;
            layer_n = L_A;
            en_n    = '0;
            nrn_n   = '0;
            wcnt_n  = '0;
            word_n  = '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        en_n    = layer_en;
                        nrn_n   = '0;
                        wcnt_n  = '0;
                        word_n  = '0;
                        state_n = S_REQ;
                        priority case (1'b1)
                            layer_en[0]: layer_n = L_A;
                            layer_en[1]: layer_n = L_B;
                            layer_en[2]: layer_n = L_C;
                            default: begin
                                layer_n = L_A;
                                state_n = S_DONE;
                            end
                        endcase
                    end
                end
                S_REQ: state_n = S_WAIT;
                S_WAIT: begin
                    if (mem_ready) begin
                        line_n  = mem_data;
                        word_n  = '0;
                        state_n = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (last_w) begin
                        // rest of the line is dropped; next neuron refetches
                        wcnt_n  = '0;
                        word_n  = '0;
                        state_n = S_REQ;
                        if (last_n) begin
                            nrn_n = '0;
                            if (layer_nx == L_NONE)
                                state_n = S_DONE;
                            else
                                layer_n = layer_nx;
                        end else begin
                            nrn_n = nrn + 1'b1;
                        end
                    end else begin
                        wcnt_n = wcnt + 1'b1;
                        if (last_word)
                            state_n = S_REQ;
                        else
                            word_n = word + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        emit_n   = (state_n == S_EMIT);
        word_val = line_n[word_n];
    end

    always_ff @(posedge clk) begin
        line_q <= line_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            layer        <= L_A;
            en_q         <= '0;
            nrn          <= '0;
            wcnt         <= '0;
            word         <= '0;
            req_mem      <= 1'b0;
            busy         <= 1'b0;
            weight_valid <= 1'b0;
            write_a      <= 1'b0;
            write_b      <= 1'b0;
            write_c      <= 1'b0;
            a_sel        <= '0;
            b_sel        <= '0;
            c_sel        <= '0;
            a_weight_sel <= '0;
            b_weight_sel <= '0;
            c_weight_sel <= '0;
            a_weight_bus <= '0;
            b_weight_bus <= '0;
            c_weight_bus <= '0;
        end else begin
            state        <= state_n;
            layer        <= layer_n;
            en_q         <= en_n;
            nrn          <= nrn_n;
            wcnt         <= wcnt_n;
            word         <= word_n;
            req_mem      <= (state_n == S_REQ);
            busy         <= (state_n inside {S_REQ, S_WAIT, S_EMIT});
            weight_valid <= (state_n == S_DONE);
            write_a      <= emit_n && layer_n == L_A;
            write_b      <= emit_n && layer_n == L_B;
            write_c      <= emit_n && layer_n == L_C;
            a_sel        <= (emit_n && layer_n == L_A) ? nrn_n[AN_W-1:0] : '0;
            b_sel        <= (emit_n && layer_n == L_B) ? nrn_n[BN_W-1:0] : '0;
            c_sel        <= (emit_n && layer_n == L_C) ? nrn_n[CN_W-1:0] : '0;
            a_weight_sel <= (emit_n && layer_n == L_A) ? wcnt_n[AW_W-1:0] : '0;
            b_weight_sel <= (emit_n && layer_n == L_B) ? wcnt_n[BW_W-1:0] : '0;
            c_weight_sel <= (emit_n && layer_n == L_C) ? wcnt_n[CW_W-1:0] : '0;
            a_weight_bus <= (emit_n && layer_n == L_A) ? word_val : '0;
            b_weight_bus <= (emit_n && layer_n == L_B) ? word_val : '0;
            c_weight_bus <= (emit_n && layer_n == L_C) ? word_val : '0;
        end
    end

`ifdef NN_WEIGHT_LD_CKSUM_EN
    logic start;
    logic [DATA_W-1:0] wr_w;

    // idle buses are held at zero, so OR-ing them selects the active one
    assign start = go && !abort && (state == S_IDLE || state == S_DONE);
    assign wr_w  = a_weight_bus | b_weight_bus | c_weight_bus;

    always_ff @(posedge clk) begin
        if (rst || abort || start)
            cksum <= '0;
        else if (write_a || write_b || write_c)
            cksum <= cksum + 32'(signed'(wr_w));
    end
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_nn_weight_ld.sv
// tb_nn_weight_ld: directed vector table plus corner-case sequences for
// nn_weight_ld, with a memory responder and a write-order reference model.
module tb_nn_weight_ld;

    localparam int DW = 16;
    localparam int LW = 32;

    logic clk = 1'b0;
    logic rst, go, abort, mem_ready;
    logic [2:0] layer_en;
    logic [LW*DW-1:0] mem_data;
    logic req_mem, write_a, write_b, write_c;
    logic [3:0] a_sel, b_sel;
    logic [5:0] c_sel;
    logic [8:0] a_weight_sel;
    logic [3:0] b_weight_sel, c_weight_sel;
    logic [DW-1:0] a_weight_bus, b_weight_bus, c_weight_bus;
    logic weight_valid, busy;
    logic [31:0] cksum;

    nn_weight_ld dut (
        .clk(clk), .rst(rst), .go(go), .layer_en(layer_en), .abort(abort),
        .mem_ready(mem_ready), .mem_data(mem_data), .req_mem(req_mem),
        .write_a(write_a), .write_b(write_b), .write_c(write_c),
        .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel),
        .a_weight_sel(a_weight_sel), .b_weight_sel(b_weight_sel),
        .c_weight_sel(c_weight_sel), .a_weight_bus(a_weight_bus),
        .b_weight_bus(b_weight_bus), .c_weight_bus(c_weight_bus),
        .weight_valid(weight_valid), .busy(busy), .cksum(cksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int WTS[3] = '{401, 16, 16};
    int NRN[3] = '{15, 15, 36};

    int n_req = 0, n_wa = 0, n_wb = 0, n_wc = 0, wr_err = 0;
    int exp_layer = 3, exp_nrn = 0, exp_w = 0;
    int last_wr_cyc = -1, first_wr_cyc = -1, go_cyc = 0;
    logic [31:0] model_sum = '0;
    bit exp_req_now = 0, prev_req = 0, prev_str = 0;
    bit stall_once = 0, stray_mode = 0, fill_ff = 0;
    bit [2:0] run_en = '0;
    logic [DW-1:0] line [LW];
    int pend = 0, wait_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int next_en(input int l);
        for (int k = l + 1; k < 3; k++)
            if (run_en[k]) return k;
        return 3;
    endfunction

    // monitor then memory responder, once per falling edge
    initial begin
        forever begin
            @(negedge clk);
            begin
                int nstr, lay, sel, ws, idx;
                logic [DW-1:0] bus;
                bit eol;
                nstr = int'(write_a) + int'(write_b) + int'(write_c);
                if (nstr > 1) wr_err++;
                if (req_mem && prev_req) wr_err++;
                if (exp_req_now && !req_mem) wr_err++;
                exp_req_now = 0;
                if (nstr == 1) begin
                    if (write_a) begin
                        lay = 0; sel = int'(a_sel);
                        ws = int'(a_weight_sel); bus = a_weight_bus; n_wa++;
                    end else if (write_b) begin
                        lay = 1; sel = int'(b_sel);
                        ws = int'(b_weight_sel); bus = b_weight_bus; n_wb++;
                    end else begin
                        lay = 2; sel = int'(c_sel);
                        ws = int'(c_weight_sel); bus = c_weight_bus; n_wc++;
                    end
                    idx = exp_w % LW;
                    if (lay != exp_layer || sel != exp_nrn || ws != exp_w
                        || bus !== line[idx]) begin
                        if (wr_err < 4)
                            $display("write err: lay %0d sel %0d ws %0d bus %0h",
                                     lay, sel, ws, bus);
                        wr_err++;
                    end
                    if (idx == 0 ? !mem_ready : !prev_str) wr_err++;
                    model_sum = model_sum + 32'(signed'(line[idx]));
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                    eol = 0;
                    if (exp_layer < 3) begin
                        exp_w++;
                        if (exp_w == WTS[exp_layer]) begin
                            exp_w = 0; exp_nrn++; eol = 1;
                            if (exp_nrn == NRN[exp_layer]) begin
                                exp_nrn = 0;
                                exp_layer = next_en(exp_layer);
                                if (exp_layer == 3) eol = 0;
                            end
                        end else if (exp_w % LW == 0) begin
                            eol = 1;
                        end
                    end
                    exp_req_now = eol;
                end
                prev_req = req_mem;
                prev_str = (nstr != 0);

                mem_ready = 1'b0;
                if (pend != 0) begin
                    if (wait_cnt == 0) begin
                        for (int i = 0; i < LW; i++) begin
                            line[i] = fill_ff ? '1 : DW'($urandom);
                            mem_data[i*DW +: DW] = line[i];
                        end
                        mem_ready = 1'b1;
                        pend = 0;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (req_mem) begin
                    n_req++;
                    pend = 1;
                    wait_cnt = stall_once ? 50 : 0;
                    stall_once = 0;
                end
                if (stray_mode && nstr != 0 && cyc % 4 == 1) begin
                    mem_ready = 1'b1;
                    mem_data = {16{$urandom}};
                end
            end
        end
    end

    task automatic start_go(input logic [2:0] en);
        @(negedge clk);
        run_en = en;
        exp_layer = next_en(-1);
        exp_nrn = 0; exp_w = 0; model_sum = '0;
        n_req = 0; n_wa = 0; n_wb = 0; n_wc = 0; wr_err = 0;
        first_wr_cyc = -1; last_wr_cyc = -1;
        layer_en = en; go = 1'b1; go_cyc = cyc;
        @(negedge clk);
        go = 1'b0; layer_en = '0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            if (weight_valid) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) $display("FAIL done_timeout: weight_valid not seen");
    endtask

    typedef struct {
        logic [2:0] en;
        int reqs, wa, wb, wc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int dc, found, snap;
        logic [31:0] exp_ck;

        vecs[0] = '{3'b111, 246, 6015, 240, 576};
        vecs[1] = '{3'b010, 15, 0, 240, 0};
        vecs[2] = '{3'b000, 0, 0, 0, 0};
        vecs[3] = '{3'b001, 195, 6015, 0, 0};
        vecs[4] = '{3'b100, 36, 0, 0, 576};
        vecs[5] = '{3'b101, 231, 6015, 0, 576};

        rst = 1'b1; go = 1'b0; abort = 1'b0; layer_en = '0;
        mem_ready = 1'b0; mem_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", req_mem, 0);
        chk("rst_wr", {write_a, write_b, write_c}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", weight_valid, 0);
        chk("rst_cksum", cksum, 0);
        chk("rst_bus", a_weight_bus, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_go(vecs[i].en);
            wait_done(20000, dc);
            chk($sformatf("v%0d_reqs", i), n_req, vecs[i].reqs);
            chk($sformatf("v%0d_wa", i), n_wa, vecs[i].wa);
            chk($sformatf("v%0d_wb", i), n_wb, vecs[i].wb);
            chk($sformatf("v%0d_wc", i), n_wc, vecs[i].wc);
            chk($sformatf("v%0d_wr_err", i), wr_err, 0);
            chk($sformatf("v%0d_busy", i), busy, 0);
            if (vecs[i].en == 3'b000) begin
                chk($sformatf("v%0d_lat", i), dc, go_cyc + 1);
            end else begin
                chk($sformatf("v%0d_lat", i), dc, last_wr_cyc + 1);
                chk($sformatf("v%0d_first", i), first_wr_cyc, go_cyc + 3);
            end
`ifdef NN_WEIGHT_LD_CKSUM_EN
            exp_ck = model_sum;
`else
            exp_ck = '0;
`endif
            chk($sformatf("v%0d_cksum", i), cksum, exp_ck);
        end

        // abort during layer A neuron 3
        start_go(3'b111);
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            if (write_a && a_sel == 4'd3 && a_weight_sel == 9'd10) begin
                found = 1;
                abort = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("abort_hit", found, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_wr", {write_a, write_b, write_c}, 0);
        chk("abort_req", req_mem, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", weight_valid, 0);
        chk("abort_sel", a_sel, 0);
        chk("abort_reqs", n_req, 40);
        snap = n_req;
        repeat (6) @(negedge clk);
        chk("abort_idle", n_req, snap);
        start_go(3'b001);
        wait_done(20000, dc);
        chk("restart_first", first_wr_cyc, go_cyc + 3);
        chk("restart_wa", n_wa, 6015);
        chk("restart_reqs", n_req, 195);
        chk("restart_wr_err", wr_err, 0);

        // long memory stall, then go and stray mem_ready pulses mid-stream
        stall_once = 1;
        stray_mode = 1;
        start_go(3'b010);
        repeat (10) @(negedge clk);
        go = 1'b1; layer_en = 3'b111;
        @(negedge clk);
        go = 1'b0; layer_en = '0;
        for (int p = 0; p < 3; p++) begin
            found = 0;
            for (int i = 0; i < 200 && found == 0; i++) begin
                if (write_b) found = 1;
                else @(negedge clk);
            end
            go = 1'b1; layer_en = 3'b111;
            @(negedge clk);
            go = 1'b0; layer_en = '0;
            repeat (25) @(negedge clk);
        end
        wait_done(20000, dc);
        stray_mode = 0;
        chk("stall_first", first_wr_cyc, go_cyc + 53);
        chk("stall_reqs", n_req, 15);
        chk("stall_wb", n_wb, 240);
        chk("stall_wac", n_wa + n_wc, 0);
        chk("stall_wr_err", wr_err, 0);
        chk("stall_lat", dc, last_wr_cyc + 1);

        // synchronous reset in the middle of layer C
        start_go(3'b100);
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            if (write_c && c_sel == 6'd2) begin
                found = 1;
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("rst_hit", found, 1);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_wr", write_c, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req", req_mem, 0);

        // all-ones weights in layer C
        fill_ff = 1;
        start_go(3'b100);
        wait_done(20000, dc);
        fill_ff = 0;
        chk("ff_wc", n_wc, 576);
        chk("ff_wr_err", wr_err, 0);
`ifdef NN_WEIGHT_LD_CKSUM_EN
        exp_ck = 32'hFFFF_FDC0;
`else
        exp_ck = '0;
`endif
        chk("ff_cksum", cksum, exp_ck);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
